// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed multi-digit 7-segment driver.
// A packed hex word is decoded nibble by nibble and shown one digit at a time.
// New data lands in a shadow register and is committed only at the frame
// boundary, so the display never shows a mix of old and new digits.
// Inputs: load and enable are sampled on the rising clock edge. A load is
// accepted on every cycle it is high; the block applies no backpressure.
// Outputs: seg/dp/an are registered and follow idx/disp/enable with one cycle
// of latency. frame is a one-cycle pulse on the first cycle of a new frame.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 1000,
  parameter int LZB            = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Inactive ("unlit") levels of the pins, polarity already applied.
  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  // Hex digit to segments {a,b,c,d,e,f,g}, 1 = lit.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1111110;
      4'h1: decode = 7'b0110000;
      4'h2: decode = 7'b1101101;
      4'h3: decode = 7'b1111001;
      4'h4: decode = 7'b0110011;
      4'h5: decode = 7'b1011011;
      4'h6: decode = 7'b1011111;
      4'h7: decode = 7'b1110000;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1111011;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b0011111;
      4'hC: decode = 7'b1001110;
      4'hD: decode = 7'b0111101;
      4'hE: decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                tick, wrap, commit;

  logic [4*DIGITS-1:0] pend_val_q, disp_val_q;
  logic [DIGITS-1:0]   pend_dp_q, disp_dp_q;
  logic [DIGITS-1:0]   pend_bl_q, disp_bl_q;
  logic                pending_q;

  logic [DIGITS-1:0]   lz_vec, blank_vec;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank;
  logic [DIGITS-1:0]   an_sel;
  logic [6:0]          seg_d, seg_q;
  logic                dp_d, dp_q, frame_q;
  logic [DIGITS-1:0]   an_d, an_q;

  assign tick   = (presc_q == PW'(DIV - 1));
  assign wrap   = tick && (idx_q == IW'(DIGITS - 1));
  assign commit = wrap && pending_q;

  // Next prescaler count and digit index.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IW'(1);
  end

  // Prescaler and scan index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Shadow capture and frame-boundary commit; a load in the commit cycle stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_bl_q  <= '0;
      pending_q  <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      disp_bl_q  <= '0;
    end else begin
      if (commit) begin
        disp_val_q <= pend_val_q;
        disp_dp_q  <= pend_dp_q;
        disp_bl_q  <= pend_bl_q;
      end
      if (load) begin
        pend_val_q <= value;
        pend_dp_q  <= dp_in;
        pend_bl_q  <= blank_in;
        pending_q  <= 1'b1;
      end else if (commit) begin
        pending_q  <= 1'b0;
      end
    end
  end

  // Per-digit blanking: forced blank, or a leading zero (digit 0 never blanked).
  always_comb begin
    logic run;
    run       = 1'b1;
    lz_vec    = '0;
    blank_vec = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run       = run && (disp_val_q[4*k +: 4] == 4'h0);
      lz_vec[k] = run;
    end
    for (int k = 0; k < DIGITS; k++) begin
      blank_vec[k] = disp_bl_q[k] | ((LZB != 0) && (k != 0) && lz_vec[k]);
    end
  end

  // Select the current digit and form the next pin levels.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    an_sel    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib   = disp_val_q[4*k +: 4];
        cur_dp    = disp_dp_q[k];
        cur_blank = blank_vec[k];
        an_sel[k] = 1'b1;
      end
    end
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    if (enable) begin
      an_d = (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;
      if (!cur_blank) begin
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~decode(cur_nib) : decode(cur_nib);
        dp_d  = (SEG_ACTIVE_LOW != 0) ? ~cur_dp : cur_dp;
      end
    end
  end

  // Output registers; frame marks the first cycle after the wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      frame_q <= wrap;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scenarios on two builds of seg7_scan_driver.
// Instance a: 4 digits, DIV=4, leading-zero blanking, active-low pins.
// Instance b: 1 digit, DIV=1, no blanking, active-high pins (decode sweep).
module tb_seg7_scan_driver;

  localparam int W = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        en_a = 1'b0, load_a = 1'b0;
  logic [15:0] value_a = '0;
  logic [3:0]  dp_in_a = '0, blank_in_a = '0;
  logic [6:0]  seg_a;
  logic        dp_a, frame_a;
  logic [3:0]  an_a;

  logic        load_b = 1'b0;
  logic [3:0]  value_b = '0;
  logic [0:0]  dp_in_b = '0, blank_in_b = '0, an_b;
  logic [6:0]  seg_b;
  logic        dp_b, frame_b;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_qb[$];

  // Reference state for instance a (cycle count since reset release).
  int          cyc;
  logic [15:0] disp_v, pend_v;
  logic [3:0]  disp_dp, pend_dp, disp_bl, pend_bl;
  logic        pending_a;
  // Reference state for instance b.
  logic [3:0]  disp_vb, pend_vb;
  logic        disp_dpb, pend_dpb, pending_b;

  seg7_scan_driver #(.DIGITS(4), .DIV(4), .LZB(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .load(load_a), .value(value_a),
    .dp_in(dp_in_a), .blank_in(blank_in_a), .seg(seg_a), .dp(dp_a), .an(an_a), .frame(frame_a)
  );

  seg7_scan_driver #(.DIGITS(1), .DIV(1), .LZB(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(1'b1), .load(load_b), .value(value_b),
    .dp_in(dp_in_b), .blank_in(blank_in_b), .seg(seg_b), .dp(dp_b), .an(an_b), .frame(frame_b)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
          7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
          7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
          7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return t[n];
  endfunction

  // Expected pins of instance a after the edge that follows cycle c.
  function automatic logic [W-1:0] exp_a(input int c, input logic [15:0] v,
                                         input logic [3:0] dpv, input logic [3:0] bl,
                                         input logic en);
    int k;
    logic [15:0] sh;
    logic blank;
    logic [6:0] s;
    logic d;
    logic [3:0] a;
    k = (c / 4) % 4;
    sh = v >> (4 * k);
    blank = bl[k] || (k != 0 && sh == 16'h0);
    s = 7'h00;
    d = 1'b0;
    a = 4'h0;
    if (en) begin
      a = 4'b0001 << k;
      if (!blank) begin
        s = ref_seg(sh[3:0]);
        d = dpv[k];
      end
    end
    return {(c % 16 == 15), ~a, ~d, ~s};
  endfunction

  function automatic logic [W-1:0] obs_a();
    return {frame_a, an_a, dp_a, seg_a};
  endfunction

  function automatic logic [W-1:0] obs_b();
    return {3'b000, frame_b, an_b, dp_b, seg_b};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    disp_v = '0; pend_v = '0; disp_dp = '0; pend_dp = '0;
    disp_bl = '0; pend_bl = '0; pending_a = 1'b0;
    disp_vb = '0; pend_vb = '0; disp_dpb = 1'b0; pend_dpb = 1'b0; pending_b = 1'b0;
  endtask

  // Pins held at their reset levels (checked asynchronously while rst_n is low).
  task automatic reset_check(input string tag);
    check({tag, "_a"}, obs_a(), {1'b0, 4'hF, 1'b1, 7'h7F});
    check({tag, "_b"}, obs_b(), 13'h0000);
  endtask

  // One clock: drive, push expectations, clock, update reference, pop and compare.
  task automatic step(input string tag, input logic la, input logic [15:0] va,
                      input logic [3:0] dpa, input logic [3:0] bla, input logic ena,
                      input logic lb, input logic [3:0] vb);
    logic wrap;
    load_a = la; value_a = va; dp_in_a = dpa; blank_in_a = bla; en_a = ena;
    load_b = lb; value_b = vb; dp_in_b = vb[0];
    exp_q.push_back(exp_a(cyc, disp_v, disp_dp, disp_bl, ena));
    exp_qb.push_back({3'b000, 1'b1, 1'b1, disp_dpb, ref_seg(disp_vb)});
    @(posedge clk);
    wrap = (cyc % 16 == 15);
    if (wrap && pending_a) begin
      disp_v = pend_v; disp_dp = pend_dp; disp_bl = pend_bl;
    end
    if (la) begin
      pend_v = va; pend_dp = dpa; pend_bl = bla; pending_a = 1'b1;
    end else if (wrap) begin
      pending_a = 1'b0;
    end
    if (pending_b) begin
      disp_vb = pend_vb; disp_dpb = pend_dpb;
    end
    if (lb) begin
      pend_vb = vb; pend_dpb = vb[0]; pending_b = 1'b1;
    end else begin
      pending_b = 1'b0;
    end
    cyc++;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0;
    check({tag, "_a"}, obs_a(), exp_q.pop_front());
    check({tag, "_b"}, obs_b(), exp_qb.pop_front());
  endtask

  task automatic idle(input string tag, input int n, input logic en);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 16'h0, 4'h0, 4'h0, en, 1'b0, 4'h0);
  endtask

  // Idle until the reference cycle count sits at the given frame phase.
  task automatic run_to(input string tag, input int ph);
    for (int i = 0; i < 16 && (cyc % 16) != ph; i++) idle(tag, 1, 1'b1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset_check("reset_init");
    rst_n = 1'b1;

    // Scan order and frame period, first data commit.
    step("scan_load", 1'b1, 16'h8765, 4'b0010, 4'h0, 1'b1, 1'b0, 4'h0);
    idle("scan", 40, 1'b1);

    // Tear-free mid-frame load.
    run_to("tear_pre", 5);
    step("tear_load", 1'b1, 16'h1234, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0);
    idle("tear", 30, 1'b1);

    // Load at the boundary while another value is still pending.
    run_to("bnd_pre", 5);
    step("bnd_load1", 1'b1, 16'h4321, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0);
    run_to("bnd_mid", 15);
    step("bnd_load2", 1'b1, 16'h9F0E, 4'b0101, 4'h0, 1'b1, 1'b0, 4'h0);
    idle("bnd", 36, 1'b1);

    // Leading-zero blanking and forced blank.
    step("lzb_load1", 1'b1, 16'h0070, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0);
    idle("lzb_0070", 36, 1'b1);
    step("lzb_load2", 1'b1, 16'h0000, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0);
    idle("lzb_0000", 36, 1'b1);
    step("lzb_load3", 1'b1, 16'h5000, 4'b1000, 4'b0001, 1'b1, 1'b0, 4'h0);
    idle("lzb_blank", 36, 1'b1);

    // Enable off then on: scan keeps running underneath.
    run_to("en_pre", 6);
    idle("en_off", 10, 1'b0);
    idle("en_on", 20, 1'b1);

    // Decode sweep on the single-digit build.
    for (int v = 0; v < 16; v++) begin
      step("dec_load", 1'b0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'(v));
      idle("dec", 2, 1'b1);
    end

    // Async reset mid-scan with data pending: pending is lost.
    run_to("rst_pre", 3);
    step("rst_load", 1'b1, 16'h7777, 4'hF, 4'h0, 1'b1, 1'b1, 4'h9);
    idle("rst_pre2", 2, 1'b1);
    #2 rst_n = 1'b0;
    #1 reset_check("reset_async");
    @(posedge clk);
    @(negedge clk);
    reset_check("reset_hold");
    rst_n = 1'b1;
    model_reset();
    idle("post_rst", 36, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode/cathode 7-segment digits, the multi-digit successor to the single-digit hex decoder. It accepts a packed hex word, decodes each nibble to segments a–g and scans the digits one at a time at a programmable rate. New values are held in a shadow register and committed only at a frame boundary, so a display never shows a mix of old and new digits. It sits between the status/data logic and the board display pins.

## Interface
- DIGITS, 4, number of digits scanned (1–8)
- DIV, 1000, clock cycles each digit is held (≥1)
- LZB, 1, 1 = blank leading zero digits (digit 0 never blanked)
- SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low when lit
- AN_ACTIVE_LOW, 1, 1 = an driven low when digit selected

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = display on, 0 = all segments and anodes inactive
- load  in  1  capture value/dp_in/blank_in into shadow register
- value  in  4*DIGITS  nibble k (bits 4k+3:4k) = digit k, digit 0 least significant
- dp_in  in  DIGITS  decimal point per digit, 1 = lit
- blank_in  in  DIGITS  force digit blank, 1 = blank
- seg  out  7  segments {a,b,c,d,e,f,g}, seg[6]=a
- dp  out  1  decimal point of current digit
- an  out  DIGITS  one-hot digit select
- frame  out  1  one-cycle pulse at each frame boundary

## Operation
- Prescaler counts 0..DIV-1; tick asserted when prescaler = DIV-1, then it wraps to 0.
- Digit index idx advances on tick, 0→1→…→DIGITS-1→0. Wrap tick = frame boundary.
- Shadow: load=1 writes pend registers and sets pending. Repeated loads before commit: last wins.
- Commit: at frame boundary with pending=1, disp ← pend, pending cleared. load in the same cycle as a commit writes pend, leaves pending=1; commit of that data occurs at the next boundary.
- Decode (abcdefg, 1=lit): 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
- Blank digit: seg all unlit, dp unlit, an still selects it. Digit k blank if blank_in-committed bit k, or LZB=1, k≠0 and nibbles k..DIGITS-1 of disp all zero.
- enable=0: seg, dp unlit; an all inactive; prescaler, idx, shadow/commit keep running.
- Polarity: SEG_ACTIVE_LOW inverts seg and dp; AN_ACTIVE_LOW inverts an; applied at output register.
- DIGITS=1: idx fixed 0; every tick is a frame boundary.

## Timing
- All outputs registered; seg/dp/an reflect idx, disp and enable of the previous cycle (1-cycle latency).
- After tick at edge N, idx changes at edge N; an/seg show new digit at edge N+1.
- frame asserted for the one cycle following the wrap edge, aligned with the first cycle disp has been updated.
- Commit-to-display latency: ≤ DIGITS*DIV + 1 cycles from load.
- Reset (async assert, sync-free release): prescaler 0, idx 0, pending 0, disp/pend 0, frame 0, seg/dp unlit, an all inactive (polarity applied). Reset mid-frame discards pending data.
- First post-reset cycle with enable=1 shows digit 0 at the following edge.

## Test plan
- Reset: DIGITS=4, SEG/AN_ACTIVE_LOW=1, rst_n=0 mid-scan -> seg=7'h7F, dp=1, an=4'hF, frame=0 immediately, pending lost.
- Decode sweep: DIGITS=1, DIV=1, LZB=0, load 0..F each frame -> seg matches table (active-high build: 8→1111111, F→1000111).
- Scan: DIGITS=4, DIV=4, enable=1 -> an one-hot 0001,0010,0100,1000 each held 4 cycles; frame every 16 cycles.
- Tear-free load: load 0x1234 mid-frame -> digits keep old value until frame pulse, then 4,3,2,1 on digits 0..3; load coinciding with boundary -> appears one frame later.
- LZB: value 0x0070, LZB=1 -> digits 3,2 blank, digit 1 shows 7, digit 0 shows 0; value 0x0000 -> only digit 0 shows 0; blank_in=4'b0001 blanks digit 0.
- enable toggle: enable=0 for 10 cycles -> outputs inactive; re-enable -> digit order continues from running idx, no restart.
